// File: rtl/sdram_frame_fetch.sv
// Framebuffer scan-out fetcher: reads bursts of 8bpp pixel words over the shared
// SDRAM port, queues them in a word FIFO and streams single pixels to the LCD stage.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no bus ownership; waits for frame activity and FIFO room
// ST_REQUEST| request raised, waiting for the compute block to yield
// ST_READ   | burst in flight; every read-valid word is pushed into the FIFO
// ST_DRAIN  | burst in flight after a frame restart; words are discarded
module sdram_frame_fetch #(
    parameter int          BURST_LEN   = 8,
    parameter int          FRAME_WORDS = 96000,
    parameter logic [21:0] BASE_ADDR   = 22'h0,
    parameter int          FIFO_DEPTH  = 32,
    parameter logic [1:0]  CMD_IDLE    = 2'd0,
    parameter logic [1:0]  CMD_READ    = 2'd1
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Frame_Start,
    output logic        o_SDRAM_Request,
    input  logic        i_SDRAM_Yield,
    output logic [1:0]  o_Command,
    output logic [21:0] o_Data_Address,
    input  logic        i_Data_Read_Valid,
    input  logic [31:0] i_Data_Read,
    output logic [7:0]  o_Pixel,
    output logic        o_Pixel_Valid,
    input  logic        i_Pixel_Ready,
    output logic        o_Underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BURST_LEN);

    localparam logic [BW-1:0] CD_LOAD    = BW'(BURST_LEN - 1);
    localparam logic [BW-1:0] CD_ONE     = BW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [21:0]   FRAME_END  = 22'(FRAME_WORDS);
    localparam logic [21:0]   BURST_STEP = 22'(BURST_LEN);
    localparam logic [CW-1:0] REQ_LIMIT  = CW'(FIFO_DEPTH - BURST_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_REQUEST, ST_READ, ST_DRAIN} state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   countdown;
    logic [21:0]     word_ptr;
    logic            frame_active;

    logic [31:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   fifo_cnt;
    // occupancy counts a word until its last byte is accepted downstream
    logic [CW-1:0]   occ;

    logic [31:0]     unp_word;
    logic            unp_valid;
    logic [1:0]      byte_idx;
    logic            pix_last;

    logic            rd_in_burst, burst_last, push;
    logic            frame_done, fetch_go;
    logic            pix_take, pix_accept, pix_load, unp_load, word_done;
    logic [7:0]      byte_sel;

    assign rd_in_burst = (state == ST_READ || state == ST_DRAIN) && i_Data_Read_Valid;
    assign burst_last  = rd_in_burst && (countdown == '0);
    assign push        = (state == ST_READ) && i_Data_Read_Valid && !i_Frame_Start;
    assign frame_done  = (word_ptr == FRAME_END) && (occ == '0);
    assign fetch_go    = frame_active && (word_ptr < FRAME_END) && (occ <= REQ_LIMIT);

    assign pix_take    = !o_Pixel_Valid || i_Pixel_Ready;
    assign pix_accept  = o_Pixel_Valid && i_Pixel_Ready;
    assign pix_load    = unp_valid && pix_take;
    assign unp_load    = (fifo_cnt != '0) && (!unp_valid || (pix_load && byte_idx == 2'd3));
    assign word_done   = pix_accept && pix_last;

    assign o_Command   = (state == ST_READ) ? CMD_READ : CMD_IDLE;

    always_comb begin
        byte_sel = unp_word[7:0];
        case (byte_idx)
            2'd0: byte_sel = unp_word[7:0];
            2'd1: byte_sel = unp_word[15:8];
            2'd2: byte_sel = unp_word[23:16];
            2'd3: byte_sel = unp_word[31:24];
            default: byte_sel = unp_word[7:0];
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!i_Frame_Start && fetch_go)
                    state_nxt = ST_REQUEST;
            end
            ST_REQUEST: begin
                if (i_Frame_Start)
                    state_nxt = ST_IDLE;
                else if (i_SDRAM_Yield)
                    state_nxt = ST_READ;
            end
            ST_READ: begin
                if (burst_last)
                    state_nxt = ST_IDLE;
                else if (i_Frame_Start)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (burst_last)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state           <= ST_IDLE;
            o_SDRAM_Request <= 1'b0;
            countdown       <= '0;
            o_Data_Address  <= BASE_ADDR;
            word_ptr        <= '0;
            frame_active    <= 1'b0;
            o_Underflow     <= 1'b0;
        end else begin
            state           <= state_nxt;
            // the controller stays ours until the burst in flight has fully returned
            o_SDRAM_Request <= (state_nxt != ST_IDLE);

            if (state == ST_REQUEST && state_nxt == ST_READ) begin
                countdown      <= CD_LOAD;
                o_Data_Address <= BASE_ADDR + word_ptr;
            end else begin
                if (rd_in_burst)
                    countdown <= countdown - CD_ONE;
                if (state == ST_READ && i_Data_Read_Valid)
                    o_Data_Address <= o_Data_Address + 22'd1;
            end

            if (i_Frame_Start)
                word_ptr <= '0;
            else if (state == ST_READ && burst_last)
                word_ptr <= word_ptr + BURST_STEP;

            if (i_Frame_Start)
                frame_active <= 1'b1;
            else if (frame_done)
                frame_active <= 1'b0;

            if (i_Frame_Start)
                o_Underflow <= 1'b0;
            else if (frame_active && word_ptr != '0 && !frame_done &&
                     i_Pixel_Ready && !o_Pixel_Valid)
                o_Underflow <= 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (push)
            mem[wr_ptr] <= i_Data_Read;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            occ           <= '0;
            unp_word      <= '0;
            unp_valid     <= 1'b0;
            byte_idx      <= 2'd0;
            pix_last      <= 1'b0;
            o_Pixel       <= 8'h00;
            o_Pixel_Valid <= 1'b0;
        end else if (i_Frame_Start) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            occ           <= '0;
            unp_valid     <= 1'b0;
            byte_idx      <= 2'd0;
            pix_last      <= 1'b0;
            o_Pixel_Valid <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;

            if (unp_load) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                unp_word  <= mem[rd_ptr];
                unp_valid <= 1'b1;
            end else if (pix_load && byte_idx == 2'd3) begin
                unp_valid <= 1'b0;
            end

            fifo_cnt <= fifo_cnt + CW'(push) - CW'(unp_load);
            occ      <= occ + CW'(push) - CW'(word_done);

            if (pix_load) begin
                o_Pixel       <= byte_sel;
                o_Pixel_Valid <= 1'b1;
                pix_last      <= (byte_idx == 2'd3);
                byte_idx      <= byte_idx + 2'd1;
            end else if (pix_accept) begin
                o_Pixel_Valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_frame_fetch.sv
// Directed bench for sdram_frame_fetch: a 64-word frame instance for fetch/flow
// behaviour and a 16-word frame instance for end-of-frame behaviour.
module tb_sdram_frame_fetch;

    localparam logic [1:0] CMD_IDLE = 2'd0;
    localparam logic [1:0] CMD_READ = 2'd1;

    logic        clk = 1'b0;
    logic        rst_n, frame_start, yield, rd_valid, ready;
    logic [31:0] rd_data;

    logic        b_req, b_pv, b_uf, s_req, s_pv, s_uf;
    logic [1:0]  b_cmd, s_cmd;
    logic [21:0] b_addr, s_addr;
    logic [7:0]  b_pix, s_pix;

    int          checks = 0;
    int          passed = 0;
    logic [7:0]  qb[$];
    logic [7:0]  qs[$];

    always #5 clk = ~clk;

    sdram_frame_fetch #(.FRAME_WORDS(64)) u_big (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Frame_Start(frame_start),
        .o_SDRAM_Request(b_req), .i_SDRAM_Yield(yield), .o_Command(b_cmd),
        .o_Data_Address(b_addr), .i_Data_Read_Valid(rd_valid), .i_Data_Read(rd_data),
        .o_Pixel(b_pix), .o_Pixel_Valid(b_pv), .i_Pixel_Ready(ready), .o_Underflow(b_uf)
    );

    sdram_frame_fetch #(.FRAME_WORDS(16)) u_small (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Frame_Start(frame_start),
        .o_SDRAM_Request(s_req), .i_SDRAM_Yield(yield), .o_Command(s_cmd),
        .o_Data_Address(s_addr), .i_Data_Read_Valid(rd_valid), .i_Data_Read(rd_data),
        .o_Pixel(s_pix), .o_Pixel_Valid(s_pv), .i_Pixel_Ready(ready), .o_Underflow(s_uf)
    );

    // pixels that will be accepted on the coming rising edge
    always @(negedge clk) begin
        if (b_pv && ready) qb.push_back(b_pix);
        if (s_pv && ready) qs.push_back(s_pix);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (b_req !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check(tag, b_req, 1);
    endtask

    task automatic serve(input string tag, input logic [21:0] addr0,
                         input logic [31:0] data0, input bit chk_small);
        wait_req({tag, "_req"});
        yield = 1'b1;
        tick();
        yield = 1'b0;
        check({tag, "_cmd"}, b_cmd, CMD_READ);
        check({tag, "_addr"}, b_addr, addr0);
        if (chk_small) check({tag, "_saddr"}, s_addr, addr0);
        for (int k = 0; k < 8; k++) begin
            rd_valid = 1'b1;
            rd_data  = data0 + 32'(k) * 32'h04040404;
            tick();
        end
        rd_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; yield = 1'b0;
        rd_valid = 1'b0; rd_data = '0; ready = 1'b1;
        ticks(3);
        check("rst_req",  b_req,  0);
        check("rst_cmd",  b_cmd,  CMD_IDLE);
        check("rst_addr", b_addr, 0);
        check("rst_pix",  b_pix,  0);
        check("rst_pv",   b_pv,   0);
        check("rst_uf",   b_uf,   0);
        rst_n = 1'b1;
        ticks(2);
        check("idle_req", b_req, 0);

        // first burst: yield withheld 3 cycles, then 8 words
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("t2_req0", b_req, 0);
        tick();
        check("t2_req1", b_req, 1);
        ticks(3);
        check("t2_hold", b_req, 1);
        check("t2_cmdi", b_cmd, CMD_IDLE);
        yield = 1'b1; tick(); yield = 1'b0;
        check("t2_cmdr", b_cmd, CMD_READ);
        for (int k = 0; k < 8; k++) begin
            check("t2_addr", b_addr, 32'(k));
            rd_valid = 1'b1;
            rd_data  = 32'h04030201 + 32'(k) * 32'h04040404;
            tick();
            if (k == 1) check("t2_lat1", b_pv, 0);
            if (k == 2) begin
                check("t2_lat2", b_pv, 1);
                check("t2_pix0", b_pix, 8'h01);
            end
        end
        rd_valid = 1'b0;
        check("t2_drop", b_req, 0);
        check("t2_cmdd", b_cmd, CMD_IDLE);
        tick();
        check("t2_rereq", b_req, 1);

        // starvation with yield withheld
        ticks(200);
        check("uf_set",  b_uf, 1);
        check("uf_pv",   b_pv, 0);
        check("uf_cnt",  qb.size(), 32);
        check("uf_px0",  qb[0], 8'h01);
        check("uf_px1",  qb[1], 8'h02);
        check("uf_px2",  qb[2], 8'h03);
        check("uf_px3",  qb[3], 8'h04);
        check("uf_px4",  qb[4], 8'h05);
        check("uf_px31", qb[31], 8'h20);
        ready = 1'b0;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("uf_clr", b_uf, 0);
        check("st_req", b_req, 0);
        check("st_pv",  b_pv, 0);
        qb.delete();

        // stalled consumer: FIFO fills to 32 words
        serve("f0", 22'd0,  32'h04030201, 1'b0);
        serve("f1", 22'd8,  32'h24232221, 1'b0);
        serve("f2", 22'd16, 32'h44434241, 1'b0);
        serve("f3", 22'd24, 32'h64636261, 1'b0);
        ticks(20);
        check("full_req", b_req, 0);
        check("full_pv",  b_pv, 1);
        check("full_pix", b_pix, 8'h01);
        check("full_cnt", qb.size(), 0);
        ticks(5);
        check("full_hold", b_pix, 8'h01);
        ready = 1'b1;
        begin
            int n = 0;
            while (b_req !== 1'b1 && n < 100) begin
                tick();
                n++;
            end
        end
        check("res_req",  b_req, 1);
        check("res_cnt",  qb.size(), 33);
        check("res_px31", qb[31], 8'h20);
        check("res_px32", qb[32], 8'h21);

        // restart on the 3rd valid of a burst
        yield = 1'b1; tick(); yield = 1'b0;
        rd_data = 32'hDEADBEEF; rd_valid = 1'b1;
        ticks(2);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("dr_req", b_req, 1);
        check("dr_cmd", b_cmd, CMD_IDLE);
        check("dr_pv",  b_pv, 0);
        qb.delete();
        ticks(5);
        rd_valid = 1'b0;
        check("dr_done", b_req, 0);
        check("dr_cnt",  qb.size(), 0);
        serve("s0", 22'd0, 32'hC3C2C1C0, 1'b0);
        check("s0_cnt", qb.size() >= 2, 1);
        check("s0_px0", qb[0], 8'hC0);
        check("s0_px1", qb[1], 8'hC1);

        // reset in the middle of a burst
        wait_req("r_req");
        yield = 1'b1; tick(); yield = 1'b0;
        rd_data = 32'h55555555; rd_valid = 1'b1;
        ticks(3);
        rst_n = 1'b0;
        #1;
        check("mr_req",  b_req,  0);
        check("mr_cmd",  b_cmd,  CMD_IDLE);
        check("mr_addr", b_addr, 0);
        check("mr_pix",  b_pix,  0);
        check("mr_pv",   b_pv,   0);
        check("mr_uf",   b_uf,   0);
        ticks(2);
        rst_n = 1'b1;
        qb.delete();
        ticks(5);
        rd_valid = 1'b0;
        ticks(10);
        check("mr_cnt",  qb.size(), 0);
        check("mr_pv2",  b_pv, 0);
        check("mr_req2", b_req, 0);

        // 16-word frame: exactly two bursts then stop
        qb.delete();
        qs.delete();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        serve("m0", 22'd0, 32'h04030201, 1'b1);
        serve("m1", 22'd8, 32'h24232221, 1'b1);
        ticks(100);
        check("sm_req",  s_req, 0);
        check("sm_cnt",  qs.size(), 64);
        check("sm_px0",  qs[0], 8'h01);
        check("sm_px63", qs[63], 8'h40);
        check("sm_pv",   s_pv, 0);
        check("sm_uf",   s_uf, 0);
        check("big_req", b_req, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
